// File: rtl/zone_alarm_pkg.sv
// Shared definitions for the multi-zone alarm controller: state encoding
// and helpers used to size the countdown timer.
package zone_alarm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_DISARMED   = 3'd0;
  localparam logic [STATE_W-1:0] ST_EXIT_DELAY = 3'd1;
  localparam logic [STATE_W-1:0] ST_ARMED      = 3'd2;
  localparam logic [STATE_W-1:0] ST_ENTRY_DELAY = 3'd3;
  localparam logic [STATE_W-1:0] ST_ALARM      = 3'd4;

  // Largest of the three delay lengths; the timer must hold (max - 1).
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Timer width, never below one bit even when every delay is a single cycle.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter used for the exit, entry and siren periods.
// Saturates at zero so a stray decrement can never wrap.
module alarm_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; reset clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/zone_alarm_ctrl.sv
// Multi-zone alarm controller: exit delay after arming, entry delay for
// delayed zones, instant zones straight to alarm, bounded siren period with
// automatic re-arm, disarm from any state and a sticky tripped-zone record.
//
// Handshake note: arm and disarm are plain levels sampled every clock; there
// is no valid/ready pairing. A refused arm is reported by a one-cycle
// arm_fault pulse, repeated for every cycle arm stays high while refused.
module zone_alarm_ctrl
  import zone_alarm_pkg::*;
#(
  parameter int N_ZONES      = 4,
  parameter int EXIT_CYCLES  = 16,
  parameter int ENTRY_CYCLES = 16,
  parameter int ALARM_CYCLES = 64,
  localparam int CNT_W = cnt_width(max3(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES))
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               disarm,
  input  logic [N_ZONES-1:0] zone_in,
  input  logic [N_ZONES-1:0] zone_mask,
  input  logic [N_ZONES-1:0] zone_instant,
  output logic [2:0]         state_o,
  output logic               siren,
  output logic [N_ZONES-1:0] tripped_zones,
  output logic               arm_fault,
  output logic [CNT_W-1:0]   timer_o
);

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [N_ZONES-1:0] active, inst, dly;
  logic [N_ZONES-1:0] tripped_q, tripped_d;
  logic               siren_q, siren_d;
  logic               arm_fault_q, arm_fault_d;
  logic               t_load, t_dec, t_zero;
  logic [CNT_W-1:0]   t_val, t_count;

  // Zone classification: masked zones never count as open.
  assign active = zone_in & ~zone_mask;
  assign inst   = active & zone_instant;
  assign dly    = active & ~zone_instant;

  alarm_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .count    (t_count),
    .zero     (t_zero)
  );

  // State register plus the registered outputs derived alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_DISARMED;
      tripped_q   <= '0;
      siren_q     <= 1'b0;
      arm_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tripped_q   <= tripped_d;
      siren_q     <= siren_d;
      arm_fault_q <= arm_fault_d;
    end
  end

  // Next-state and timer control: disarm beats triggers, triggers beat expiry.
  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_dec   = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (arm && !disarm && (active == '0)) begin
          state_d = ST_EXIT_DELAY;
          t_load  = 1'b1;
          t_val   = EXIT_LOAD;
        end
      end
      ST_EXIT_DELAY: begin
        if (disarm) begin
          state_d = ST_DISARMED;
          t_load  = 1'b1;
        end else if (t_zero) begin
          state_d = ST_ARMED;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_ARMED: begin
        if (disarm) begin
          state_d = ST_DISARMED;
          t_load  = 1'b1;
        end else if (inst != '0) begin
          state_d = ST_ALARM;
          t_load  = 1'b1;
          t_val   = ALARM_LOAD;
        end else if (dly != '0) begin
          state_d = ST_ENTRY_DELAY;
          t_load  = 1'b1;
          t_val   = ENTRY_LOAD;
        end
      end
      ST_ENTRY_DELAY: begin
        if (disarm) begin
          state_d = ST_DISARMED;
          t_load  = 1'b1;
        end else if ((inst != '0) || t_zero) begin
          state_d = ST_ALARM;
          t_load  = 1'b1;
          t_val   = ALARM_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_ALARM: begin
        if (disarm) begin
          state_d = ST_DISARMED;
          t_load  = 1'b1;
        end else if (t_zero) begin
          state_d = ST_ARMED;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        // Unused encodings recover to DISARMED with a cleared timer.
        state_d = ST_DISARMED;
        t_load  = 1'b1;
      end
    endcase
  end

  // Output decode: siren follows the next state, fault and tripped latch.
  always_comb begin
    siren_d     = (state_d == ST_ALARM);
    arm_fault_d = 1'b0;
    tripped_d   = tripped_q;
    case (state_q)
      ST_DISARMED: begin
        if (arm && !disarm) begin
          if (active != '0) begin
            arm_fault_d = 1'b1;
          end else begin
            tripped_d = '0;
          end
        end
      end
      // In ARMED, active is non-zero only when a transition is taken.
      ST_ARMED, ST_ENTRY_DELAY, ST_ALARM: begin
        if (!disarm) begin
          tripped_d = tripped_q | active;
        end
      end
      default: begin
        tripped_d = tripped_q;
      end
    endcase
  end

  assign state_o       = state_q;
  assign siren         = siren_q;
  assign tripped_zones = tripped_q;
  assign arm_fault     = arm_fault_q;
  assign timer_o       = t_count;

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Self-checking bench for zone_alarm_ctrl with default parameters
// (4 zones, 16/16/64 cycle delays, 6-bit timer).
module tb_zone_alarm_ctrl;

  localparam int W = 15;  // {state[2:0], siren, tripped[3:0], arm_fault, timer[5:0]}

  logic       clk;
  logic       rst;
  logic       arm;
  logic       disarm;
  logic [3:0] zone_in;
  logic [3:0] zone_mask;
  logic [3:0] zone_instant;
  logic [2:0] state_o;
  logic       siren;
  logic [3:0] tripped_zones;
  logic       arm_fault;
  logic [5:0] timer_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  logic [W-1:0] exp;
  int           n_run;
  int           n_fail;

  zone_alarm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .disarm        (disarm),
    .zone_in       (zone_in),
    .zone_mask     (zone_mask),
    .zone_instant  (zone_instant),
    .state_o       (state_o),
    .siren         (siren),
    .tripped_zones (tripped_zones),
    .arm_fault     (arm_fault),
    .timer_o       (timer_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [W-1:0] obs_w = {state_o, siren, tripped_zones, arm_fault, timer_o};

  function automatic logic [W-1:0] pk(input logic [2:0] s, input logic sr,
                                      input logic [3:0] tz, input logic af,
                                      input logic [5:0] tm);
    return {s, sr, tz, af, tm};
  endfunction

  // Driver: apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic a, input logic d, input logic [3:0] zi,
                       input logic [3:0] zm, input logic [3:0] zinst);
    arm          = a;
    disarm       = d;
    zone_in      = zi;
    zone_mask    = zm;
    zone_instant = zinst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b0, 6'd0));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL reset: got %h expected %h", got, exp); end
    end
    rst = 1'b0;
  endtask

  task automatic test_arm_fault;
    // Open unmasked zone: arm refused, fault re-pulses while arm is held.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b1, 6'd0));
      drive(1'b1, 1'b0, 4'b0010, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL arm_fault_pulse: got %h expected %h", got, exp); end
    end
    exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b0, 6'd0));
    drive(1'b0, 1'b0, 4'b0010, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL arm_fault_clear: got %h expected %h", got, exp); end
    // Same zone masked: arm accepted.
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'd15));
    drive(1'b1, 1'b0, 4'b0010, 4'b0010, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL arm_masked: got %h expected %h", got, exp); end
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'(15 - k)));
      drive(1'b0, 1'b0, 4'b0010, 4'b0010, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL exit_count k=%0d: got %h expected %h", k, got, exp); end
    end
    // 16th cycle after arm: ARMED; masked open zone must not trigger.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(3'd2, 1'b0, 4'h0, 1'b0, 6'd0));
      drive(1'b0, 1'b0, 4'b0010, 4'b0010, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL armed_masked: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_entry_alarm;
    exp_q.push_back(pk(3'd3, 1'b0, 4'b0001, 1'b0, 6'd15));
    drive(1'b0, 1'b0, 4'b0001, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL entry_start: got %h expected %h", got, exp); end
    for (int k = 1; k <= 15; k++) begin
      exp_q.push_back(pk(3'd3, 1'b0, 4'b0001, 1'b0, 6'(15 - k)));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL entry_count k=%0d: got %h expected %h", k, got, exp); end
    end
    exp_q.push_back(pk(3'd4, 1'b1, 4'b0001, 1'b0, 6'd63));
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL alarm_start: got %h expected %h", got, exp); end
    for (int k = 1; k <= 63; k++) begin
      exp_q.push_back(pk(3'd4, 1'b1, 4'b0001, 1'b0, 6'(63 - k)));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL alarm_count k=%0d: got %h expected %h", k, got, exp); end
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(3'd2, 1'b0, 4'b0001, 1'b0, 6'd0));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL rearm: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_instant_in_entry;
    exp_q.push_back(pk(3'd3, 1'b0, 4'b0001, 1'b0, 6'd15));
    drive(1'b0, 1'b0, 4'b0001, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL inst_entry_start: got %h expected %h", got, exp); end
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(pk(3'd3, 1'b0, 4'b0001, 1'b0, 6'(15 - k)));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL inst_entry_count k=%0d: got %h expected %h", k, got, exp); end
    end
    // Timer now at 10: instant zone 3 opens.
    exp_q.push_back(pk(3'd4, 1'b1, 4'b1001, 1'b0, 6'd63));
    drive(1'b0, 1'b0, 4'b1000, 4'h0, 4'b1000);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL inst_alarm: got %h expected %h", got, exp); end
    exp_q.push_back(pk(3'd4, 1'b1, 4'b1001, 1'b0, 6'd62));
    drive(1'b0, 1'b0, 4'b1000, 4'h0, 4'b1000);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL inst_alarm_hold: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid_alarm;
    rst = 1'b1;
    exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b0, 6'd0));
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_mid_alarm: got %h expected %h", got, exp); end
    rst = 1'b0;
    exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b0, 6'd0));
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL after_reset_idle: got %h expected %h", got, exp); end
  endtask

  task automatic test_disarm_entry;
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'd15));
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL de_arm: got %h expected %h", got, exp); end
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back((k == 16) ? pk(3'd2, 1'b0, 4'h0, 1'b0, 6'd0)
                                : pk(3'd1, 1'b0, 4'h0, 1'b0, 6'(15 - k)));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL de_exit k=%0d: got %h expected %h", k, got, exp); end
    end
    exp_q.push_back(pk(3'd3, 1'b0, 4'b0010, 1'b0, 6'd15));
    drive(1'b0, 1'b0, 4'b0010, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL de_entry: got %h expected %h", got, exp); end
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(pk(3'd3, 1'b0, 4'b0010, 1'b0, 6'(15 - k)));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL de_entry_count k=%0d: got %h expected %h", k, got, exp); end
    end
    // Timer at 5: disarm wins; tripped record survives.
    exp_q.push_back(pk(3'd0, 1'b0, 4'b0010, 1'b0, 6'd0));
    drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL de_disarm: got %h expected %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(3'd0, 1'b0, 4'b0010, 1'b0, 6'd0));
      drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL de_retain: got %h expected %h", got, exp); end
    end
  endtask

  task automatic test_arm_disarm;
    // Both together in DISARMED: no move, no fault, record untouched.
    exp_q.push_back(pk(3'd0, 1'b0, 4'b0010, 1'b0, 6'd0));
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL arm_and_disarm: got %h expected %h", got, exp); end
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'd15));
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL ad_arm_clears: got %h expected %h", got, exp); end
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'd14));
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL ad_exit: got %h expected %h", got, exp); end
    exp_q.push_back(pk(3'd0, 1'b0, 4'h0, 1'b0, 6'd0));
    drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL ad_disarm_exit: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back;
    // Arm, then hold an instant zone open through a full siren period:
    // auto re-arm must immediately re-trigger.
    logic [3:0] zm_rand;
    zm_rand = 4'($urandom_range(0, 3));  // random mask on zones 0..1 only
    exp_q.push_back(pk(3'd1, 1'b0, 4'h0, 1'b0, 6'd15));
    drive(1'b1, 1'b0, 4'h0, zm_rand, 4'h0);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL bb_arm: got %h expected %h", got, exp); end
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back((k == 16) ? pk(3'd2, 1'b0, 4'h0, 1'b0, 6'd0)
                                : pk(3'd1, 1'b0, 4'h0, 1'b0, 6'(15 - k)));
      // Zones are ignored during exit delay even when open.
      drive(1'b0, 1'b0, (k < 16) ? 4'b0100 : 4'h0, zm_rand, 4'b0100);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL bb_exit k=%0d: got %h expected %h", k, got, exp); end
    end
    exp_q.push_back(pk(3'd4, 1'b1, 4'b0100, 1'b0, 6'd63));
    drive(1'b0, 1'b0, 4'b0100, zm_rand, 4'b0100);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL bb_alarm1: got %h expected %h", got, exp); end
    for (int k = 1; k <= 64; k++) begin
      exp_q.push_back((k == 64) ? pk(3'd2, 1'b0, 4'b0100, 1'b0, 6'd0)
                                : pk(3'd4, 1'b1, 4'b0100, 1'b0, 6'(63 - k)));
      drive(1'b0, 1'b0, 4'b0100, zm_rand, 4'b0100);
      got = obs_w; exp = exp_q.pop_front(); n_run++;
      if (got !== exp) begin n_fail++; $display("FAIL bb_alarm_count k=%0d: got %h expected %h", k, got, exp); end
    end
    exp_q.push_back(pk(3'd4, 1'b1, 4'b0100, 1'b0, 6'd63));
    drive(1'b0, 1'b0, 4'b0100, zm_rand, 4'b0100);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL bb_retrigger: got %h expected %h", got, exp); end
    exp_q.push_back(pk(3'd0, 1'b0, 4'b0100, 1'b0, 6'd0));
    drive(1'b0, 1'b1, 4'b0100, zm_rand, 4'b0100);
    got = obs_w; exp = exp_q.pop_front(); n_run++;
    if (got !== exp) begin n_fail++; $display("FAIL bb_disarm: got %h expected %h", got, exp); end
  endtask

  initial begin
    n_run        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    arm          = 1'b0;
    disarm       = 1'b0;
    zone_in      = 4'h0;
    zone_mask    = 4'h0;
    zone_instant = 4'h0;
    @(posedge clk);
    #1;
    test_reset;
    test_arm_fault;
    test_entry_alarm;
    test_instant_in_entry;
    test_reset_mid_alarm;
    test_disarm_entry;
    test_arm_disarm;
    test_back_to_back;
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
